// File: rtl/serial_adder.sv
// Bit-serial adder: one full-adder slice per cycle, operands shifted LSB-first; optional SERIAL_ADDER_OVF_EN adds port ovf.
// Latency: accept at edge k, result valid after edge k+WIDTH; one operation in flight at a time.
// Backpressure: in_ready only in IDLE; result held in DONE until out_ready, no input queuing.
module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout
`ifdef SERIAL_ADDER_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int CW = $clog2(WIDTH + 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]       state;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] sum_sh;
    logic             carry;
    logic [CW-1:0]    cnt;

    logic             slice_sum;
    logic             slice_carry;
    logic             last_slice;
    logic             accept;

    // Handshakes decode straight from the state register.
    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign accept    = in_valid && in_ready;

    assign sum  = sum_sh;
    assign cout = carry;

    // One-bit full-adder slice on the current operand LSBs and the carry flop.
    always_comb begin
        slice_sum   = a_sh[0] ^ b_sh[0] ^ carry;
        slice_carry = (a_sh[0] & b_sh[0]) | (a_sh[0] & carry) | (b_sh[0] & carry);
        last_slice  = (cnt == CW'(WIDTH - 1));
    end

    // State sequencing: IDLE -> RUN for exactly WIDTH cycles -> DONE until consumed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            case (state)
                IDLE:    if (accept)     state <= RUN;
                RUN:     if (last_slice) state <= DONE;
                DONE:    if (out_ready)  state <= IDLE;
                default:                 state <= IDLE;
            endcase
        end
    end

    // Datapath: load on accept, shift one bit per RUN cycle, hold otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sh   <= '0;
            b_sh   <= '0;
            sum_sh <= '0;
            carry  <= 1'b0;
            cnt    <= '0;
        end else if (state == IDLE) begin
            if (accept) begin
                a_sh  <= a;
                b_sh  <= b;
                carry <= cin;
                cnt   <= '0;
            end
        end else if (state == RUN) begin
            // Sum bits enter at the MSB so the word is LSB-aligned after WIDTH shifts.
            sum_sh <= {slice_sum, sum_sh[WIDTH-1:1]};
            a_sh   <= a_sh >> 1;
            b_sh   <= b_sh >> 1;
            carry  <= slice_carry;
            cnt    <= cnt + CW'(1);
        end
    end

`ifdef SERIAL_ADDER_OVF_EN
    // Signed overflow: carry into the MSB slice differs from the carry out of it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf <= 1'b0;
        end else if (state == RUN && last_slice) begin
            ovf <= carry ^ slice_carry;
        end
    end
`endif

endmodule

// File: tb/tb_serial_adder.sv
module tb_serial_adder;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         cout;
`ifdef SERIAL_ADDER_OVF_EN
    logic         ovf;
`endif

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    serial_adder #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout)
`ifdef SERIAL_ADDER_OVF_EN
        ,
        .ovf       (ovf)
`endif
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Reference: plain integer addition, result split into {cout, sum}.
    function automatic logic [W:0] ref_add(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
        longint t;
        t = longint'(x) + longint'(y) + longint'(c);
        return t[W:0];
    endfunction

    // Reference: signed result of x+y+c falls outside the W-bit two's-complement range.
    function automatic logic ref_ovf(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
        longint sx, sy, s;
        sx = x[W-1] ? longint'(x) - (longint'(1) << W) : longint'(x);
        sy = y[W-1] ? longint'(y) - (longint'(1) << W) : longint'(y);
        s  = sx + sy + longint'(c);
        return (s > (longint'(1) << (W - 1)) - 1) || (s < -(longint'(1) << (W - 1)));
    endfunction

    // Full transaction; call with clk low. Ends at a falling edge with the block back in IDLE.
    task automatic run_op(input logic [W-1:0] oa, input logic [W-1:0] ob, input logic oc,
                          input int hold, input string tag);
        logic [W:0]   e;
        logic [W-1:0] s0;
        logic         c0;
        int           n;
        e = ref_add(oa, ob, oc);
        check({tag, "/in_ready_idle"}, 64'(in_ready), 64'(1));
        a = oa; b = ob; cin = oc; in_valid = 1'b1; out_ready = 1'b0;
        @(posedge clk);
        #1;
        // Busy-time inputs are garbage with in_valid still high; they must be ignored.
        a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
        n = 0;
        do begin
            @(posedge clk);
            n++;
            @(negedge clk);
        end while (!out_valid && n < 4 * W);
        check({tag, "/latency"}, 64'(n), 64'(W));
        check({tag, "/sum"}, 64'(sum), 64'(e[W-1:0]));
        check({tag, "/cout"}, 64'(cout), 64'(e[W]));
`ifdef SERIAL_ADDER_OVF_EN
        check({tag, "/ovf"}, 64'(ovf), 64'(ref_ovf(oa, ob, oc)));
`endif
        s0 = sum; c0 = cout;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            @(negedge clk);
            a = W'($urandom); b = W'($urandom);
            check({tag, "/hold_valid"}, 64'(out_valid), 64'(1));
            check({tag, "/hold_in_ready"}, 64'(in_ready), 64'(0));
            check({tag, "/hold_sum"}, 64'({c0, sum} != {cout, s0}), 64'(0));
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0; out_ready = 1'b0;
        @(negedge clk);
        check({tag, "/out_valid_after"}, 64'(out_valid), 64'(0));
        check({tag, "/in_ready_after"}, 64'(in_ready), 64'(1));
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        a = '0; b = '0; cin = 1'b0;
        #3;
        check("reset/in_ready", 64'(in_ready), 64'(1));
        check("reset/out_valid", 64'(out_valid), 64'(0));
        check("reset/sum", 64'(sum), 64'(0));
        check("reset/cout", 64'(cout), 64'(0));
`ifdef SERIAL_ADDER_OVF_EN
        check("reset/ovf", 64'(ovf), 64'(0));
`endif
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed cases, including first edge after reset release.
        run_op(8'h0F, 8'h01, 1'b0, 0, "d_0f_01");
        run_op(8'hFF, 8'h01, 1'b0, 1, "d_ff_01");
        run_op(8'hFF, 8'hFF, 1'b1, 0, "d_ff_ff_c");
        run_op(8'h00, 8'h00, 1'b0, 0, "d_zero");
        run_op(8'hA5, 8'h3C, 1'b1, 5, "d_hold5");
        run_op(8'h7F, 8'h01, 1'b0, 0, "d_ovf_7f");
        run_op(8'h80, 8'hFF, 1'b0, 0, "d_ovf_80");
        run_op(8'h05, 8'hFE, 1'b0, 0, "d_ovf_05");

        // Reset asserted mid-RUN after three slices.
        check("rst_mid/in_ready", 64'(in_ready), 64'(1));
        a = 8'hAA; b = 8'h55; cin = 1'b0; in_valid = 1'b1;
        @(posedge clk);
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_mid/out_valid", 64'(out_valid), 64'(0));
        check("rst_mid/sum", 64'(sum), 64'(0));
        check("rst_mid/cout", 64'(cout), 64'(0));
        check("rst_mid/in_ready", 64'(in_ready), 64'(1));
        in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        run_op(8'h12, 8'h34, 1'b0, 0, "rst_after");
        for (int k = 0; k < W + 4; k++) begin
            @(negedge clk);
            if (k == W + 3) check("rst_after/no_stray", 64'(out_valid), 64'(0));
        end

        // Randomized operations with random output backpressure.
        for (int i = 0; i < 40; i++) begin
            run_op(W'($urandom), W'($urandom), 1'($urandom), int'($urandom_range(0, 3)), "rand");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
